// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : parking_pkg
//  Description : Shared types, defaults and helpers for zone occupancy logic.
//  Revision    : 1.0  initial release
// ============================================================================
package parking_pkg;

  localparam int c_NUM_ZONES_DEF = 4;
  localparam int c_CNT_W_DEF     = 8;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic over_capacity;
  } zone_flags_t;

  // Zone index width; a single zone still gets a 1-bit selector.
  function automatic int zidx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zone_counter.sv
`default_nettype none
// ============================================================================
//  Module      : zone_counter
//  Description : One parking zone: occupancy/capacity registers, event
//                arbitration and registered status flags.
//  Revision    : 1.0  initial release
// ============================================================================
module zone_counter
  import parking_pkg::*;
#(
  parameter int CNT_W         = c_CNT_W_DEF,
  parameter int DEFAULT_CAP   = 200,
  parameter int ALMOST_MARGIN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_entry,
  input  logic             i_exit,
  input  logic             i_cap_wr,
  input  logic [CNT_W-1:0] i_cap_data,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_avail,
  output zone_flags_t      o_flags,
  output logic             o_entry_reject,
  output logic             o_exit_underflow,
  output logic [CNT_W-1:0] o_count_nxt,
  output logic             o_full_nxt
);

  localparam logic [CNT_W-1:0] c_DEF_CAP = CNT_W'(DEFAULT_CAP);
  localparam logic [CNT_W-1:0] c_MARGIN  = CNT_W'(ALMOST_MARGIN);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_cap;
  logic [CNT_W-1:0] r_avail;
  zone_flags_t      r_flags;
  logic             r_reject;
  logic             r_underflow;

  logic             w_entry_only;
  logic             w_exit_only;
  logic             w_has_room;
  logic             w_inc;
  logic             w_dec;
  logic             w_reject;
  logic             w_underflow;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_cap_nxt;
  logic [CNT_W-1:0] w_avail_nxt;
  zone_flags_t      w_flags_nxt;

  // Simultaneous entry and exit cancel out, so neither raises an error pulse.
  assign w_entry_only = i_entry & ~i_exit;
  assign w_exit_only  = i_exit & ~i_entry;
  assign w_has_room   = (r_count < r_cap);

  assign w_inc       = w_entry_only & w_has_room;
  assign w_dec       = w_exit_only & (r_count != '0);
  assign w_reject    = w_entry_only & ~w_has_room;
  assign w_underflow = w_exit_only & (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_inc) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_dec) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Events above are judged against the old capacity; the new one only
  // affects the flags derived below.
  assign w_cap_nxt = i_cap_wr ? i_cap_data : r_cap;

  always_comb begin
    w_flags_nxt               = '0;
    w_flags_nxt.full          = (w_count_nxt >= w_cap_nxt);
    w_flags_nxt.over_capacity = (w_count_nxt > w_cap_nxt);
    w_avail_nxt               = w_flags_nxt.full ? '0 : (w_cap_nxt - w_count_nxt);
    w_flags_nxt.almost_full   = ~w_flags_nxt.full & (w_avail_nxt <= c_MARGIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count               <= '0;
      r_cap                 <= c_DEF_CAP;
      r_avail               <= c_DEF_CAP;
      r_flags.full          <= (c_DEF_CAP == '0);
      r_flags.almost_full   <= 1'b0;
      r_flags.over_capacity <= 1'b0;
      r_reject              <= 1'b0;
      r_underflow           <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_cap       <= w_cap_nxt;
      r_avail     <= w_avail_nxt;
      r_flags     <= w_flags_nxt;
      r_reject    <= w_reject;
      r_underflow <= w_underflow;
    end
  end

  assign o_count          = r_count;
  assign o_avail          = r_avail;
  assign o_flags          = r_flags;
  assign o_entry_reject   = r_reject;
  assign o_exit_underflow = r_underflow;
  assign o_count_nxt      = w_count_nxt;
  assign o_full_nxt       = w_flags_nxt.full;

endmodule
`default_nettype wire

// File: rtl/zone_occupancy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : zone_occupancy_counter
//  Description : Multi-zone parking occupancy tracker with programmable
//                per-zone capacity and lot-wide aggregate outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module zone_occupancy_counter
  import parking_pkg::*;
#(
  parameter int NUM_ZONES     = c_NUM_ZONES_DEF,
  parameter int CNT_W         = c_CNT_W_DEF,
  parameter int DEFAULT_CAP   = 200,
  parameter int ALMOST_MARGIN = 4,
  parameter int ZIDX_W        = zidx_w(NUM_ZONES)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_ZONES-1:0]       i_entry_pulse,
  input  logic [NUM_ZONES-1:0]       i_exit_pulse,
  input  logic                       i_cap_wr_en,
  input  logic [ZIDX_W-1:0]          i_cap_wr_zone,
  input  logic [CNT_W-1:0]           i_cap_wr_data,
  output logic [NUM_ZONES*CNT_W-1:0] o_zone_count,
  output logic [NUM_ZONES*CNT_W-1:0] o_zone_avail,
  output logic [NUM_ZONES-1:0]       o_zone_full,
  output logic [NUM_ZONES-1:0]       o_zone_almost_full,
  output logic [NUM_ZONES-1:0]       o_over_capacity,
  output logic [NUM_ZONES-1:0]       o_entry_reject,
  output logic [NUM_ZONES-1:0]       o_exit_underflow,
  output logic [CNT_W+ZIDX_W-1:0]    o_total_count,
  output logic                       o_lot_full
);

  localparam int TOT_W = CNT_W + ZIDX_W;

  logic [NUM_ZONES-1:0] w_cap_wr;
  logic [CNT_W-1:0]     w_cnt_nxt [NUM_ZONES];
  logic [NUM_ZONES-1:0] w_full_nxt;
  zone_flags_t          w_flags   [NUM_ZONES];
  logic [TOT_W-1:0]     w_total_nxt;
  logic [TOT_W-1:0]     r_total;
  logic                 r_lot_full;

  generate
    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
      // Out-of-range zone indices never match, so such writes are dropped.
      assign w_cap_wr[z] = i_cap_wr_en && (i_cap_wr_zone == ZIDX_W'(z));

      zone_counter #(
        .CNT_W         (CNT_W),
        .DEFAULT_CAP   (DEFAULT_CAP),
        .ALMOST_MARGIN (ALMOST_MARGIN)
      ) u_zone (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_entry          (i_entry_pulse[z]),
        .i_exit           (i_exit_pulse[z]),
        .i_cap_wr         (w_cap_wr[z]),
        .i_cap_data       (i_cap_wr_data),
        .o_count          (o_zone_count[z*CNT_W +: CNT_W]),
        .o_avail          (o_zone_avail[z*CNT_W +: CNT_W]),
        .o_flags          (w_flags[z]),
        .o_entry_reject   (o_entry_reject[z]),
        .o_exit_underflow (o_exit_underflow[z]),
        .o_count_nxt      (w_cnt_nxt[z]),
        .o_full_nxt       (w_full_nxt[z])
      );

      assign o_zone_full[z]        = w_flags[z].full;
      assign o_zone_almost_full[z] = w_flags[z].almost_full;
      assign o_over_capacity[z]    = w_flags[z].over_capacity;
    end
  endgenerate

  // Aggregates are built from next-state zone values to match zone latency.
  always_comb begin
    w_total_nxt = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      w_total_nxt = w_total_nxt + TOT_W'(w_cnt_nxt[z]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total    <= '0;
      r_lot_full <= (DEFAULT_CAP == 0);
    end else begin
      r_total    <= w_total_nxt;
      r_lot_full <= &w_full_nxt;
    end
  end

  assign o_total_count = r_total;
  assign o_lot_full    = r_lot_full;

endmodule
`default_nettype wire

// File: tb/tb_zone_occupancy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zone_occupancy_counter
//  Description : Self-checking bench for zone_occupancy_counter (4 zones).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_zone_occupancy_counter;

  localparam int NZ  = 4;
  localparam int CW  = 8;
  localparam int ZW  = 2;
  localparam int DEF = 200;
  localparam int MRG = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NZ-1:0]     entry = '0;
  logic [NZ-1:0]     exitp = '0;
  logic              wr_en = 1'b0;
  logic [ZW-1:0]     wr_zone = '0;
  logic [CW-1:0]     wr_data = '0;
  logic [NZ*CW-1:0]  zone_count;
  logic [NZ*CW-1:0]  zone_avail;
  logic [NZ-1:0]     zone_full;
  logic [NZ-1:0]     zone_almost;
  logic [NZ-1:0]     over_cap;
  logic [NZ-1:0]     ent_rej;
  logic [NZ-1:0]     ex_unf;
  logic [CW+ZW-1:0]  total;
  logic              lot_full;

  zone_occupancy_counter #(
    .NUM_ZONES(NZ), .CNT_W(CW), .DEFAULT_CAP(DEF), .ALMOST_MARGIN(MRG)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_entry_pulse      (entry),
    .i_exit_pulse       (exitp),
    .i_cap_wr_en        (wr_en),
    .i_cap_wr_zone      (wr_zone),
    .i_cap_wr_data      (wr_data),
    .o_zone_count       (zone_count),
    .o_zone_avail       (zone_avail),
    .o_zone_full        (zone_full),
    .o_zone_almost_full (zone_almost),
    .o_over_capacity    (over_cap),
    .o_entry_reject     (ent_rej),
    .o_exit_underflow   (ex_unf),
    .o_total_count      (total),
    .o_lot_full         (lot_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NZ*CW-1:0] count;
    logic [NZ*CW-1:0] avail;
    logic [NZ-1:0]    full;
    logic [NZ-1:0]    almost;
    logic [NZ-1:0]    over;
    logic [NZ-1:0]    rej;
    logic [NZ-1:0]    unf;
    logic [CW+ZW-1:0] total;
    logic             lot;
  } exp_t;

  typedef struct {
    logic [NZ-1:0] en;
    logic [NZ-1:0] ex;
    logic          wr;
    logic [ZW-1:0] wz;
    logic [CW-1:0] wd;
    logic [31:0]   exp_count;
    logic [NZ-1:0] exp_rej;
    logic [NZ-1:0] exp_unf;
    logic [NZ-1:0] exp_full;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt [NZ];
  int   m_cap [NZ];
  exp_t sb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_outputs(input logic [NZ-1:0] rej, input logic [NZ-1:0] unf);
    exp_t e;
    int   av;
    e = '0;
    for (int z = 0; z < NZ; z++) begin
      av = (m_cnt[z] >= m_cap[z]) ? 0 : m_cap[z] - m_cnt[z];
      e.count[z*CW +: CW] = CW'(m_cnt[z]);
      e.avail[z*CW +: CW] = CW'(av);
      e.full[z]   = (m_cnt[z] >= m_cap[z]);
      e.over[z]   = (m_cnt[z] > m_cap[z]);
      e.almost[z] = !e.full[z] && (av <= MRG);
      e.total     = e.total + (CW+ZW)'(m_cnt[z]);
    end
    e.rej = rej;
    e.unf = unf;
    e.lot = &e.full;
    return e;
  endfunction

  task automatic model_reset();
    for (int z = 0; z < NZ; z++) begin
      m_cnt[z] = 0;
      m_cap[z] = DEF;
    end
    sb_q.delete();
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".count"},  64'(zone_count),  64'(e.count));
    chk({tag, ".avail"},  64'(zone_avail),  64'(e.avail));
    chk({tag, ".full"},   64'(zone_full),   64'(e.full));
    chk({tag, ".almost"}, 64'(zone_almost), 64'(e.almost));
    chk({tag, ".over"},   64'(over_cap),    64'(e.over));
    chk({tag, ".rej"},    64'(ent_rej),     64'(e.rej));
    chk({tag, ".unf"},    64'(ex_unf),      64'(e.unf));
    chk({tag, ".total"},  64'(total),       64'(e.total));
    chk({tag, ".lot"},    64'(lot_full),    64'(e.lot));
  endtask

  // Drive one cycle of stimulus, push model prediction, compare after the edge.
  task automatic step(input string tag, input logic [NZ-1:0] en, input logic [NZ-1:0] ex,
                      input logic wr, input logic [ZW-1:0] wz, input logic [CW-1:0] wd);
    logic [NZ-1:0] rej;
    logic [NZ-1:0] unf;
    exp_t          e;
    entry = en; exitp = ex; wr_en = wr; wr_zone = wz; wr_data = wd;
    rej = '0; unf = '0;
    for (int z = 0; z < NZ; z++) begin
      if (en[z] && !ex[z]) begin
        if (m_cnt[z] < m_cap[z]) m_cnt[z]++; else rej[z] = 1'b1;
      end else if (ex[z] && !en[z]) begin
        if (m_cnt[z] > 0) m_cnt[z]--; else unf[z] = 1'b1;
      end
      if (wr && (int'(wz) == z)) m_cap[z] = int'(wd);
    end
    sb_q.push_back(model_outputs(rej, unf));
    @(posedge clk);
    #1;
    entry = '0; exitp = '0; wr_en = 1'b0;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_all(tag, e);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    entry = '0; exitp = '0; wr_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  vec_t vecs [9];
  exp_t rst_e;

  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 8'd3, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 8'd0, 32'h0000_0100, 4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 8'd0, 32'h0000_0200, 4'b0000, 4'b0000, 4'b0000};
    vecs[3] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 8'd0, 32'h0000_0300, 4'b0000, 4'b0000, 4'b0010};
    vecs[4] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 8'd0, 32'h0000_0300, 4'b0010, 4'b0000, 4'b0010};
    vecs[5] = '{4'b0000, 4'b0100, 1'b0, 2'd0, 8'd0, 32'h0000_0300, 4'b0000, 4'b0100, 4'b0010};
    vecs[6] = '{4'b0010, 4'b0010, 1'b0, 2'd0, 8'd0, 32'h0000_0300, 4'b0000, 4'b0000, 4'b0010};
    vecs[7] = '{4'b0001, 4'b0100, 1'b0, 2'd0, 8'd0, 32'h0000_0301, 4'b0000, 4'b0100, 4'b0010};
    vecs[8] = '{4'b1111, 4'b0000, 1'b0, 2'd0, 8'd0, 32'h0101_0302, 4'b0010, 4'b0000, 4'b0010};

    do_reset();
    rst_e = model_outputs('0, '0);
    check_all("reset", rst_e);
    chk("reset.avail_lit", 64'(zone_avail), 64'h0000_0000_C8C8_C8C8);
    chk("reset.lot_lit",   64'(lot_full),   64'd0);

    for (int i = 0; i < 9; i++) begin
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].ex, vecs[i].wr, vecs[i].wz, vecs[i].wd);
      chk($sformatf("vec%0d.count_lit", i), 64'(zone_count),  64'(vecs[i].exp_count));
      chk($sformatf("vec%0d.rej_lit", i),   64'(ent_rej),     64'(vecs[i].exp_rej));
      chk($sformatf("vec%0d.unf_lit", i),   64'(ex_unf),      64'(vecs[i].exp_unf));
      chk($sformatf("vec%0d.full_lit", i),  64'(zone_full),   64'(vecs[i].exp_full));
    end

    // Zone 0 up to 10, then shrink its capacity to 6.
    while (m_cnt[0] < 10) step("z0_fill", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0);
    step("z0_shrink", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd6);
    chk("shrink.over_lit",  64'(over_cap[0]),         64'd1);
    chk("shrink.avail_lit", 64'(zone_avail[7:0]),     64'd0);
    step("z0_rej", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0);
    chk("shrink.rej_lit",   64'(ent_rej[0]),          64'd1);
    for (int i = 0; i < 5; i++) step("z0_exit", 4'b0000, 4'b0001, 1'b0, 2'd0, 8'd0);
    chk("drain.count_lit",  64'(zone_count[7:0]),     64'd5);
    chk("drain.avail_lit",  64'(zone_avail[7:0]),     64'd1);
    chk("drain.almost_lit", 64'(zone_almost[0]),      64'd1);
    chk("drain.over_lit",   64'(over_cap[0]),         64'd0);

    // Same-cycle write and entry: entry judged against the old capacity.
    step("wr_race", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd5);
    chk("wr_race.count_lit", 64'(zone_count[7:0]),   64'd6);
    chk("wr_race.over_lit",  64'(over_cap[0]),       64'd1);

    // Lot full across all zones.
    do_reset();
    for (int z = 0; z < NZ; z++) step("cap2", 4'b0000, 4'b0000, 1'b1, ZW'(z), 8'd2);
    step("fill1", 4'b1111, 4'b0000, 1'b0, 2'd0, 8'd0);
    chk("fill1.lot_lit", 64'(lot_full), 64'd0);
    step("fill2", 4'b1111, 4'b0000, 1'b0, 2'd0, 8'd0);
    chk("fill2.lot_lit",   64'(lot_full), 64'd1);
    chk("fill2.total_lit", 64'(total),    64'd8);
    step("unfill", 4'b0000, 4'b0100, 1'b0, 2'd0, 8'd0);
    chk("unfill.lot_lit",   64'(lot_full), 64'd0);
    chk("unfill.total_lit", 64'(total),    64'd7);

    // Asynchronous reset in the middle of a burst.
    entry = 4'b1111; exitp = 4'b0010;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    rst_e = model_outputs('0, '0);
    check_all("async_rst", rst_e);
    chk("async_rst.total_lit", 64'(total), 64'd0);
    entry = '0; exitp = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post_rst", 4'b1000, 4'b0000, 1'b0, 2'd0, 8'd0);
    chk("post_rst.count_lit", 64'(zone_count), 64'h0100_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
